// File: rtl/fifo_pop_arbiter_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO pop arbiter slice.
//   arb_state_t : arbiter FSM state encoding
//   clog2()     : index width helper (never returns less than 1)
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      STALL = 2'd2
   } arb_state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/fifo_pop_arbiter_if.sv
// fifo_pop_arbiter_if: bundle between the FIFO bank / downstream link and the arbiter.
//   enable, fifo_count, fifo_data, out_almost_full : towards the arbiter
//   rd_en, data_out, valid_out, grant_idx, busy    : from the arbiter
// slave modport = arbiter side, master modport = environment side.
interface fifo_pop_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_FIFOS  = 4,
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned CNT_WIDTH  = 4
);
   localparam int unsigned IW = clog2(NUM_FIFOS);

   logic                              enable;
   logic [NUM_FIFOS*CNT_WIDTH-1:0]    fifo_count;
   logic [NUM_FIFOS*DATA_WIDTH-1:0]   fifo_data;
   logic                              out_almost_full;
   logic [NUM_FIFOS-1:0]              rd_en;
   logic [DATA_WIDTH-1:0]             data_out;
   logic                              valid_out;
   logic [IW-1:0]                     grant_idx;
   logic                              busy;

   modport slave (
      input  enable, fifo_count, fifo_data, out_almost_full,
      output rd_en, data_out, valid_out, grant_idx, busy
   );

   modport master (
      output enable, fifo_count, fifo_data, out_almost_full,
      input  rd_en, data_out, valid_out, grant_idx, busy
   );

endinterface

// File: rtl/fifo_pop_arbiter_rr_pick.sv
// fifo_rr_pick: combinational rotate-priority encoder.
//   eligible : request vector
//   start    : index scanned first; scan continues start+1, ... modulo N
//   found    : some request is set
//   idx      : first set index in scan order (0 when none)
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]          eligible,
   input  logic [clog2(N)-1:0]   start,
   output logic                  found,
   output logic [clog2(N)-1:0]   idx
);
   localparam int unsigned IW = clog2(N);

   always_comb begin
      int unsigned j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int unsigned off = 0; off < N; off++) begin
         j = (32'(start) + off) % N;
         if (!found && eligible[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: round-robin pop scheduler sharing one downstream port
// between NUM_FIFOS source FIFOs, with bursts of up to MAX_BURST pops per
// grant, stall on downstream almost-full and a 2-cycle registered read path.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fifo_pop_arbiter_if.slave (enable, counts, data, almost-full in;
//          rd_en, data_out, valid_out, grant_idx, busy out)
module fifo_pop_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_FIFOS  = 4,
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned CNT_WIDTH  = 4,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                clk,
   input  logic                rst,
   fifo_pop_arbiter_if.slave   bus
);
   localparam int unsigned IW = clog2(NUM_FIFOS);

   arb_state_t               state, state_n;
   logic [IW-1:0]            ptr, ptr_n, cur, cur_n, cur_inc;
   logic [IW-1:0]            pick0_idx, pick1_idx, pop_idx, idx_d1;
   logic [CNT_WIDTH-1:0]     burst_cnt, burst_n;
   logic [NUM_FIFOS-1:0]     eligible;
   logic                     pick0_found, pick1_found;
   logic                     pop, pop_ok, pop_d1;

   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NUM_FIFOS; i++)
         eligible[i] = (bus.fifo_count[i*CNT_WIDTH +: CNT_WIDTH] != '0);
   end

   assign cur_inc = (cur == IW'(NUM_FIFOS - 1)) ? '0 : cur + 1'b1;
   assign pop_ok  = bus.enable & ~bus.out_almost_full & ~rst;

   fifo_rr_pick #(.N(NUM_FIFOS)) u_pick_ptr (
      .eligible (eligible),
      .start    (ptr),
      .found    (pick0_found),
      .idx      (pick0_idx)
   );

   fifo_rr_pick #(.N(NUM_FIFOS)) u_pick_next (
      .eligible (eligible),
      .start    (cur_inc),
      .found    (pick1_found),
      .idx      (pick1_idx)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cur_n   = cur;
      burst_n = burst_cnt;
      pop     = 1'b0;
      pop_idx = cur;
      case (state)
         IDLE: begin
            if (pop_ok && pick0_found) begin
               pop     = 1'b1;
               pop_idx = pick0_idx;
               cur_n   = pick0_idx;
               burst_n = CNT_WIDTH'(1);
               state_n = BURST;
            end
         end
         BURST, STALL: begin
            // BURST and STALL share the grant-continuation logic; only the
            // priority of almost-full versus disable differs between them.
            if (state == BURST && bus.out_almost_full) begin
               state_n = STALL;
            end else if (!bus.enable) begin
               ptr_n   = cur_inc;
               state_n = IDLE;
            end else if (bus.out_almost_full) begin
               state_n = STALL;
            end else if (eligible[cur] && (burst_cnt < CNT_WIDTH'(MAX_BURST))) begin
               pop     = 1'b1;
               burst_n = burst_cnt + 1'b1;
               state_n = BURST;
            end else if (pick1_found) begin
               pop     = 1'b1;
               pop_idx = pick1_idx;
               cur_n   = pick1_idx;
               burst_n = CNT_WIDTH'(1);
               state_n = BURST;
            end else begin
               ptr_n   = cur_inc;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.rd_en = '0;
      if (pop && pop_ok) bus.rd_en[pop_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ptr           <= '0;
         cur           <= '0;
         burst_cnt     <= '0;
         pop_d1        <= 1'b0;
         idx_d1        <= '0;
         bus.valid_out <= 1'b0;
         bus.data_out  <= '0;
      end else begin
         state         <= state_n;
         ptr           <= ptr_n;
         cur           <= cur_n;
         burst_cnt     <= burst_n;
         pop_d1        <= pop & pop_ok;
         idx_d1        <= pop_idx;
         bus.valid_out <= pop_d1;
         if (pop_d1)
            bus.data_out <= bus.fifo_data[idx_d1*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.grant_idx = cur;
   assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Bench for fifo_pop_arbiter: queue-based FIFO bank model, a rule-level
// reference scheduler, directed vector tables and a randomized phase.
module tb_fifo_pop_arbiter;
   import fifo_arb_pkg::*;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int CW = 4;
   localparam int MB = 4;

   typedef logic [DW-1:0] word_t;

   typedef struct {
      bit          r;
      bit          en;
      bit          af;
      logic [N-1:0] rd;
      bit          v;
      word_t       d;
      bit          b;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_pop_arbiter_if #(.NUM_FIFOS(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_pop_arbiter #(
      .NUM_FIFOS  (N),
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW),
      .MAX_BURST  (MB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   word_t fq [N][$];
   word_t fdata [N];
   vec_t  tbl [$];

   // reference scheduler state
   bit    m_granted, m_stalled, n_granted, n_stalled;
   int    m_cur, m_ptr, m_burst, n_cur, n_ptr, n_burst;
   int    m_pop;
   bit    m_pd1, m_valid;
   word_t m_wd1, m_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int pick(input int s);
      for (int o = 0; o < N; o++) begin
         int j;
         j = (s + o) % N;
         if (fq[j].size() > 0) return j;
      end
      return -1;
   endfunction

   task automatic drive(input bit r, input bit en, input bit af);
      rst = r;
      bus.enable = en;
      bus.out_almost_full = af;
      for (int k = 0; k < N; k++) begin
         bus.fifo_count[k*CW +: CW] = CW'(fq[k].size());
         bus.fifo_data[k*DW +: DW]  = fdata[k];
      end
   endtask

   task automatic decide(input bit r, input bit en, input bit af);
      int g;
      n_granted = m_granted; n_stalled = m_stalled;
      n_cur = m_cur; n_ptr = m_ptr; n_burst = m_burst;
      m_pop = -1;
      if (r) begin
         n_granted = 0; n_stalled = 0; n_cur = 0; n_ptr = 0; n_burst = 0;
      end else if (!m_granted) begin
         if (en && !af) begin
            g = pick(m_ptr);
            if (g >= 0) begin
               m_pop = g; n_cur = g; n_burst = 1; n_granted = 1;
            end
         end
      end else if (!m_stalled && af) begin
         n_stalled = 1;
      end else if (!en) begin
         n_granted = 0; n_stalled = 0; n_ptr = (m_cur + 1) % N;
      end else if (!af) begin
         n_stalled = 0;
         if (fq[m_cur].size() > 0 && m_burst < MB) begin
            m_pop = m_cur; n_burst = m_burst + 1;
         end else begin
            g = pick((m_cur + 1) % N);
            if (g >= 0) begin
               m_pop = g; n_cur = g; n_burst = 1;
            end else begin
               n_granted = 0; n_ptr = (m_cur + 1) % N;
            end
         end
      end
   endtask

   task automatic commit(input bit r);
      if (r) begin
         m_valid = 0; m_data = '0; m_pd1 = 0;
      end else begin
         m_valid = m_pd1;
         if (m_pd1) m_data = m_wd1;
         m_pd1 = (m_pop >= 0);
         if (m_pop >= 0) m_wd1 = fq[m_pop][0];
      end
      if (m_pop >= 0) fdata[m_pop] = fq[m_pop].pop_front();
      m_granted = n_granted; m_stalled = n_stalled;
      m_cur = n_cur; m_ptr = n_ptr; m_burst = n_burst;
   endtask

   // One clock: drive after negedge, check rd_en before the edge,
   // check registered outputs just after it, return at the next negedge.
   task automatic cycle(input bit r, input bit en, input bit af, output logic [N-1:0] act_rd);
      logic [N-1:0] exp_rd;
      drive(r, en, af);
      #1;
      decide(r, en, af);
      exp_rd = (m_pop >= 0) ? N'(1 << m_pop) : '0;
      act_rd = bus.rd_en;
      check("model_rd_en", 32'(bus.rd_en), 32'(exp_rd));
      @(posedge clk);
      #1;
      commit(r);
      drive(r, en, af);
      check("model_valid", 32'(bus.valid_out), 32'(m_valid));
      check("model_data", 32'(bus.data_out), 32'(m_data));
      check("model_busy", 32'(bus.busy), 32'(m_granted));
      check("model_grant", 32'(bus.grant_idx), 32'(m_cur));
      @(negedge clk);
   endtask

   task automatic add(input bit r, input bit en, input bit af, input logic [N-1:0] rd,
                      input bit v, input word_t d, input bit b);
      vec_t e;
      e.r = r; e.en = en; e.af = af; e.rd = rd; e.v = v; e.d = d; e.b = b;
      tbl.push_back(e);
   endtask

   task automatic run_tbl(input string name);
      logic [N-1:0] act;
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].r, tbl[i].en, tbl[i].af, act);
         check({name, "_rd"}, 32'(act), 32'(tbl[i].rd));
         check({name, "_valid"}, 32'(bus.valid_out), 32'(tbl[i].v));
         check({name, "_data"}, 32'(bus.data_out), 32'(tbl[i].d));
         check({name, "_busy"}, 32'(bus.busy), 32'(tbl[i].b));
      end
      tbl.delete();
   endtask

   task automatic clear_fifos();
      for (int k = 0; k < N; k++) fq[k].delete();
   endtask

   initial begin
      logic [N-1:0] act;
      m_granted = 0; m_stalled = 0; m_cur = 0; m_ptr = 0; m_burst = 0;
      m_pd1 = 0; m_valid = 0; m_wd1 = '0; m_data = '0; m_pop = -1;
      for (int k = 0; k < N; k++) fdata[k] = '0;
      drive(1, 0, 0);
      @(negedge clk);

      // reset with all FIFOs holding 5 words
      for (int k = 0; k < N; k++)
         for (int w = 0; w < 5; w++) fq[k].push_back(word_t'(k + w));
      for (int i = 0; i < 3; i++) add(1, 1, 0, 4'b0000, 0, 4'h0, 0);
      run_tbl("reset");

      // single source F0 = {1,2,3}
      clear_fifos();
      fq[0] = '{4'h1, 4'h2, 4'h3};
      add(0, 1, 0, 4'b0001, 0, 4'h0, 1);
      add(0, 1, 0, 4'b0001, 1, 4'h1, 1);
      add(0, 1, 0, 4'b0001, 1, 4'h2, 1);
      add(0, 1, 0, 4'b0000, 1, 4'h3, 0);
      add(0, 1, 0, 4'b0000, 0, 4'h3, 0);
      run_tbl("single");

      // one word in F1 leaves the pointer at 2
      fq[1] = '{4'h9};
      add(0, 1, 0, 4'b0010, 0, 4'h3, 1);
      add(0, 1, 0, 4'b0000, 1, 4'h9, 0);
      add(0, 1, 0, 4'b0000, 0, 4'h9, 0);
      run_tbl("ptr_setup");

      // wrap and skip: counts {0,1,0,2} from pointer 2
      fq[1] = '{4'h5};
      fq[3] = '{4'h6, 4'h7};
      add(0, 1, 0, 4'b1000, 0, 4'h9, 1);
      add(0, 1, 0, 4'b1000, 1, 4'h6, 1);
      add(0, 1, 0, 4'b0010, 1, 4'h7, 1);
      add(0, 1, 0, 4'b0000, 1, 4'h5, 0);
      add(0, 1, 0, 4'b0000, 0, 4'h5, 0);
      run_tbl("wrap");

      // burst rotation with every FIFO holding 8 words
      cycle(1, 1, 0, act);
      for (int k = 0; k < N; k++)
         for (int w = 0; w < 8; w++) fq[k].push_back(word_t'($urandom_range(0, 15)));
      for (int i = 0; i < 20; i++) begin
         logic [N-1:0] want;
         want = N'(1 << ((i / MB) % N));
         cycle(0, 1, 0, act);
         check("rotation", 32'(act), 32'(want));
      end

      // stall after two F1 pops, then mid-burst reset
      clear_fifos();
      fq[1] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      fq[2] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
      add(1, 1, 0, 4'b0000, 0, 4'h0, 0);
      add(0, 1, 0, 4'b0010, 0, 4'h0, 1);
      add(0, 1, 0, 4'b0010, 1, 4'h1, 1);
      add(0, 1, 1, 4'b0000, 1, 4'h2, 1);
      add(0, 1, 1, 4'b0000, 0, 4'h2, 1);
      add(0, 1, 1, 4'b0000, 0, 4'h2, 1);
      add(0, 1, 0, 4'b0010, 0, 4'h2, 1);
      add(0, 1, 0, 4'b0010, 1, 4'h3, 1);
      add(0, 1, 0, 4'b0100, 1, 4'h4, 1);
      add(0, 1, 0, 4'b0100, 1, 4'h9, 1);
      run_tbl("stall");

      fq[0] = '{4'h6, 4'h7};
      add(1, 1, 0, 4'b0000, 0, 4'h0, 0);
      add(0, 1, 0, 4'b0001, 0, 4'h0, 1);
      add(0, 1, 0, 4'b0001, 1, 4'h6, 1);
      add(0, 1, 0, 4'b0010, 1, 4'h7, 1);
      run_tbl("midreset");

      // randomized traffic against the reference scheduler
      for (int i = 0; i < 1500; i++) begin
         bit r, en, af;
         for (int k = 0; k < N; k++)
            if (fq[k].size() < 15 && $urandom_range(0, 3) == 0)
               fq[k].push_back(word_t'($urandom_range(0, 15)));
         r  = ($urandom_range(0, 63) == 0);
         en = ($urandom_range(0, 7) != 0);
         af = ($urandom_range(0, 4) == 0);
         cycle(r, en, af, act);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
